seven_segment_decoder: RTL and testbench

SEVEN_SEGMENT_DECODER -- requirements
Module: seven_segment_decoder

---
 rtl/seven_segment_decoder.sv | 161 ++++++++++++++++
 tb/tb_seven_segment_decoder.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/seven_segment_decoder.sv
// Recovers digit values from a multiplexed seven-segment display bus.
// Each digit is captured after a stable dwell and assembled into frames.
module seven_segment_decoder #(
  parameter int DIGITS        = 4,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [7:0]            segmentEnableN,
  input  logic [DIGITS-1:0]     digitEnableN,
  output logic [4*DIGITS-1:0]   data,
  output logic [DIGITS-1:0]     pointEnable,
  output logic                  frameValid,
  output logic                  frameError,
  output logic                  badPattern
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [7:0] LAST = 8'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETTLING,
    HELD
  } state_t;

  state_t              state;
  logic [7:0]          cnt;
  logic [7:0]          seg_q;
  logic [7:0]          seg_p;
  logic [DIGITS-1:0]   dig_q;
  logic [DIGITS-1:0]   dig_p;
  logic [4*DIGITS-1:0] shadow_nib;
  logic [DIGITS-1:0]   shadow_pt;
  logic [DIGITS-1:0]   seen;
  logic [DIGITS-1:0]   slot_err;

  int                  nzero;
  logic                strobe_ok;
  logic [IW-1:0]       idx;
  logic                changed;
  logic                restart;
  logic                capture;
  logic [6:0]          pat;
  logic [3:0]          nib;
  logic                undec;

  always_comb begin
    nzero = 0;
    idx   = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!dig_q[i]) begin
        nzero = nzero + 1;
        idx   = IW'(i);
      end
    end
    strobe_ok = (nzero == 1);
  end

  // dig_p/seg_p hold the registered sample from the previous cycle
  assign changed = (dig_q != dig_p) || (seg_q != seg_p);
  assign restart = (state == IDLE) || changed;

  always_comb begin
    capture = 1'b0;
    if (strobe_ok) begin
      if (restart)
        capture = (SETTLE_CYCLES == 1);
      else if (state == SETTLING)
        capture = (cnt == LAST);
    end
  end

  assign pat = ~seg_q[6:0];

  always_comb begin
    nib   = 4'h0;
    undec = 1'b0;
    case (pat)
      7'h3F: nib = 4'h0;
      7'h06: nib = 4'h1;
      7'h5B: nib = 4'h2;
      7'h4F: nib = 4'h3;
      7'h66: nib = 4'h4;
      7'h6D: nib = 4'h5;
      7'h7D: nib = 4'h6;
      7'h07: nib = 4'h7;
      7'h7F: nib = 4'h8;
      7'h6F: nib = 4'h9;
      7'h77: nib = 4'hA;
      7'h7C: nib = 4'hB;
      7'h39: nib = 4'hC;
      7'h5E: nib = 4'hD;
      7'h79: nib = 4'hE;
      7'h71: nib = 4'hF;
      default: undec = 1'b1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      seg_q <= '1;
      seg_p <= '1;
      dig_q <= '1;
      dig_p <= '1;
      state <= IDLE;
      cnt   <= '0;
    end else begin
      seg_q <= segmentEnableN;
      seg_p <= seg_q;
      dig_q <= digitEnableN;
      dig_p <= dig_q;
      if (!strobe_ok) begin
        state <= IDLE;
        cnt   <= '0;
      end else if (restart) begin
        cnt   <= 8'd1;
        state <= capture ? HELD : SETTLING;
      end else if (state == SETTLING) begin
        cnt   <= cnt + 8'd1;
        state <= capture ? HELD : SETTLING;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      data        <= '0;
      pointEnable <= '0;
      frameValid  <= 1'b0;
      frameError  <= 1'b0;
      badPattern  <= 1'b0;
      shadow_nib  <= '0;
      shadow_pt   <= '0;
      seen        <= '0;
      slot_err    <= '0;
    end else begin
      frameValid <= 1'b0;
      frameError <= 1'b0;
      badPattern <= capture && undec;
      if (&seen) begin
        data        <= shadow_nib;
        pointEnable <= shadow_pt;
        frameValid  <= 1'b1;
        frameError  <= |slot_err;
        seen        <= '0;
        slot_err    <= '0;
      end
      // a capture in the commit cycle lands in the next frame
      for (int i = 0; i < DIGITS; i++) begin
        if (capture && idx == IW'(i)) begin
          shadow_nib[4*i +: 4] <= nib;
          shadow_pt[i]         <= ~seg_q[7];
          seen[i]              <= 1'b1;
          slot_err[i]          <= undec;
        end
      end
    end
  end

endmodule

// File: tb/tb_seven_segment_decoder.sv
// Scoreboard bench for seven_segment_decoder.
// Expected frames are queued at stimulus time and popped on frameValid.
module tb_seven_segment_decoder;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  segmentEnableN = '1;
  logic [3:0]  digitEnableN = '1;
  logic [15:0] data;
  logic [3:0]  pointEnable;
  logic        frameValid;
  logic        frameError;
  logic        badPattern;

  seven_segment_decoder #(
    .DIGITS(4),
    .SETTLE_CYCLES(4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .segmentEnableN(segmentEnableN),
    .digitEnableN(digitEnableN),
    .data(data),
    .pointEnable(pointEnable),
    .frameValid(frameValid),
    .frameError(frameError),
    .badPattern(badPattern)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [15:0] d;
    logic [3:0]  p;
    logic        e;
  } frame_t;

  frame_t sb[$];
  frame_t got_f;
  int     n_cmp = 0;
  int     n_bad = 0;
  int     bad_seen = 0;
  bit     mon_on = 1'b0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  always @(negedge clock) begin
    if (mon_on) begin
      if (badPattern === 1'b1) bad_seen++;
      if (frameValid === 1'b1) begin
        if (sb.size() == 0) begin
          check("unexpected_frame", 32'd1, 32'd0);
        end else begin
          got_f = sb.pop_front();
          check("frame_data", {16'd0, data}, {16'd0, got_f.d});
          check("frame_point", {28'd0, pointEnable}, {28'd0, got_f.p});
          check("frame_error", {31'd0, frameError}, {31'd0, got_f.e});
        end
      end else if (frameError !== 1'b0) begin
        check("error_unqualified", {31'd0, frameError}, 32'd0);
      end
    end
  end

  task automatic push(input logic [15:0] d, input logic [3:0] p,
                      input logic e);
    frame_t f;
    f.d = d;
    f.p = p;
    f.e = e;
    sb.push_back(f);
  endtask

  task automatic show(input int idx, input logic [7:0] pat,
                      input int dwell);
    if (idx < 0) digitEnableN = '1;
    else digitEnableN = ~(4'b0001 << idx);
    segmentEnableN = ~pat;
    repeat (dwell) @(negedge clock);
  endtask

  task automatic scan(input logic [7:0] p0, input logic [7:0] p1,
                      input logic [7:0] p2, input logic [7:0] p3);
    show(0, p0, 10);
    show(1, p1, 10);
    show(2, p2, 10);
    show(3, p3, 10);
  endtask

  task automatic idle(input string tag);
    show(-1, 8'h00, 10);
    check(tag, sb.size(), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clock);
    check("rst_data", {16'd0, data}, 32'd0);
    check("rst_point", {28'd0, pointEnable}, 32'd0);
    check("rst_valid", {31'd0, frameValid}, 32'd0);
    check("rst_error", {31'd0, frameError}, 32'd0);
    check("rst_bad", {31'd0, badPattern}, 32'd0);
    reset  = 1'b0;
    mon_on = 1'b1;

    push(16'h4321, 4'b0000, 1'b0);
    scan(8'h06, 8'h5B, 8'h4F, 8'h66);
    idle("t_basic_pending");
    check("t_basic_bad", bad_seen, 32'd0);

    show(0, 8'h07, 10);
    show(1, 8'h7D, 10);
    show(2, 8'h6D, 3);
    show(3, 8'h6F, 10);
    idle("t_short_pending");
    check("t_short_hold", {16'd0, data}, 32'h4321);
    push(16'h9567, 4'b0000, 1'b0);
    show(2, 8'h6D, 10);
    idle("t_short_done");

    push(16'h3200, 4'b0010, 1'b1);
    scan(8'h3F, 8'h80, 8'h5B, 8'h4F);
    idle("t_undec_pending");
    check("t_undec_bad", bad_seen, 32'd1);

    digitEnableN   = 4'b1100;
    segmentEnableN = ~8'h06;
    repeat (20) @(negedge clock);
    idle("t_multi_pending");
    check("t_multi_data", {16'd0, data}, 32'h3200);
    check("t_multi_point", {28'd0, pointEnable}, 32'h2);
    check("t_multi_bad", bad_seen, 32'd1);

    push(16'h1111, 4'b0000, 1'b0);
    show(0, 8'h00, 10);
    scan(8'h06, 8'h06, 8'h06, 8'h06);
    idle("t_over_pending");
    check("t_over_bad", bad_seen, 32'd2);

    show(0, 8'h06, 10);
    show(1, 8'h06, 10);
    show(2, 8'h06, 10);
    reset        = 1'b1;
    digitEnableN = '1;
    repeat (3) @(negedge clock);
    check("t_rst_data", {16'd0, data}, 32'd0);
    check("t_rst_point", {28'd0, pointEnable}, 32'd0);
    reset = 1'b0;
    push(16'h8888, 4'b0000, 1'b0);
    show(3, 8'h7F, 10);
    show(0, 8'h7F, 10);
    show(1, 8'h7F, 10);
    show(2, 8'h7F, 10);
    idle("t_rst_pending");

    for (int k = 0; k < 3; k++) begin
      push(16'hDCBA, 4'b1000, 1'b0);
      scan(8'h77, 8'h7C, 8'h39, 8'hDE);
    end
    idle("t_cont_pending");
    check("t_cont_bad", bad_seen, 32'd2);

    push(16'h98FE, 4'b0000, 1'b0);
    scan(8'h79, 8'h71, 8'h7F, 8'h6F);
    for (int k = 0; k < 200 && sb.size() != 0; k++)
      @(negedge clock);
    check("final_pending", sb.size(), 32'd0);
    check("final_bad", bad_seen, 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
